// File: rtl/uart_rx_param.sv
// uart_rx_param: oversampling UART receiver with valid/ready output and sticky errors; parity bit compiled in by `UART_RX_PARITY_EN.
// Latency: rx_valid rises one cycle after the stop-bit sample point.
// Backpressure: a character finishing while rx_data is unconsumed (and rx_ready low) is dropped and flags overrun.
module uart_rx_param #(
  parameter int CLKS_PER_BIT = 868,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_ODD   = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 serialIn,
  input  logic                 rx_ready,
  input  logic                 err_clear,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic [2:0]           err
);

`ifdef UART_RX_PARITY_EN
  localparam logic PAR_EN = 1'b1;
`else
  localparam logic PAR_EN = 1'b0;
`endif

  localparam logic [11:0] HALF_LOAD = 12'(CLKS_PER_BIT / 2 - 1);
  localparam logic [11:0] BIT_LOAD  = 12'(CLKS_PER_BIT - 1);
  localparam logic [3:0]  LAST_BIT  = 4'(DATA_BITS - 1);
  localparam logic        PAR_SENSE = (PARITY_ODD != 0);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t               state, state_nxt;
  logic                 rx_meta, rx_s;
  logic [11:0]          timer, timer_nxt;
  logic [3:0]           bit_cnt, bit_cnt_nxt;
  logic [DATA_BITS-1:0] shreg, shreg_nxt;
  logic                 par_bit, par_bit_nxt;
  logic                 commit, load, mismatch;
  logic [DATA_BITS-1:0] rx_data_nxt;
  logic                 rx_valid_nxt, frame_err_nxt, parity_err_nxt;
  logic [2:0]           err_nxt;

  // Synchroniser idles high so reset never looks like a start bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= serialIn;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      timer      <= '0;
      bit_cnt    <= '0;
      shreg      <= '0;
      par_bit    <= 1'b0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      err        <= '0;
    end else begin
      state      <= state_nxt;
      timer      <= timer_nxt;
      bit_cnt    <= bit_cnt_nxt;
      shreg      <= shreg_nxt;
      par_bit    <= par_bit_nxt;
      rx_data    <= rx_data_nxt;
      rx_valid   <= rx_valid_nxt;
      frame_err  <= frame_err_nxt;
      parity_err <= parity_err_nxt;
      err        <= err_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    timer_nxt   = timer;
    bit_cnt_nxt = bit_cnt;
    shreg_nxt   = shreg;
    par_bit_nxt = par_bit;
    commit      = 1'b0;
    if (state != IDLE && timer != 12'd0)
      timer_nxt = timer - 12'd1;
    case (state)
      IDLE: begin
        if (!rx_s) begin
          timer_nxt = HALF_LOAD;
          state_nxt = START;
        end
      end
      START: begin
        if (timer == 12'd0) begin
          if (rx_s) begin
            state_nxt = IDLE;
          end else begin
            timer_nxt   = BIT_LOAD;
            bit_cnt_nxt = 4'd0;
            state_nxt   = DATA;
          end
        end
      end
      DATA: begin
        if (timer == 12'd0) begin
          shreg_nxt   = {rx_s, shreg[DATA_BITS-1:1]};
          timer_nxt   = BIT_LOAD;
          bit_cnt_nxt = bit_cnt + 4'd1;
          if (bit_cnt == LAST_BIT)
            state_nxt = PAR_EN ? PARITY : STOP;
        end
      end
      PARITY: begin
        if (timer == 12'd0) begin
          par_bit_nxt = rx_s;
          timer_nxt   = BIT_LOAD;
          state_nxt   = STOP;
        end
      end
      STOP: begin
        if (timer == 12'd0) begin
          commit    = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Commit: rx_s is the stop-bit sample in this cycle; shreg holds the full character.
  always_comb begin
    mismatch       = PAR_EN & (par_bit ^ (^shreg) ^ PAR_SENSE);
    load           = commit & (~rx_valid | rx_ready);
    rx_data_nxt    = rx_data;
    rx_valid_nxt   = rx_valid;
    frame_err_nxt  = frame_err;
    parity_err_nxt = parity_err;
    err_nxt        = err_clear ? 3'b000 : err;
    if (load) begin
      rx_data_nxt    = shreg;
      rx_valid_nxt   = 1'b1;
      frame_err_nxt  = ~rx_s;
      parity_err_nxt = mismatch;
    end else if (rx_valid && rx_ready) begin
      rx_valid_nxt = 1'b0;
    end
    if (commit)
      err_nxt = err_nxt | {~load, mismatch, ~rx_s};
  end

endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: directed scenarios plus random frames against a frame-level reference model.
module tb_uart_rx_param;
  localparam int CPB = 16;
  localparam int DB  = 8;
  localparam int ODD = 0;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          serialIn = 1'b1;
  logic          rx_ready = 1'b1;
  logic          err_clear = 1'b0;
  logic [DB-1:0] rx_data;
  logic          rx_valid, frame_err, parity_err;
  logic [2:0]    err;

  int         checks = 0;
  int         errors = 0;
  logic [9:0] got_q[$];
  logic [9:0] exp_q[$];
  logic [2:0] m_err = 3'b000;
  logic       held = 1'b0;
  logic [9:0] held_ch = '0;

  always #5 clk = ~clk;

  uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB), .PARITY_ODD(ODD)) dut (
    .clk(clk), .reset(reset), .serialIn(serialIn), .rx_ready(rx_ready),
    .err_clear(err_clear), .rx_data(rx_data), .rx_valid(rx_valid),
    .frame_err(frame_err), .parity_err(parity_err), .err(err)
  );

  // Every handshake seen by the consumer, as {frame_err, parity_err, data}.
  always @(negedge clk)
    if (!reset && rx_valid && rx_ready)
      got_q.push_back({frame_err, parity_err, rx_data});

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic logic good_par(input logic [7:0] d);
    return (^d) ^ 1'(ODD);
  endfunction

  function automatic logic mism(input logic [7:0] d, input logic p);
`ifdef UART_RX_PARITY_EN
    return p != good_par(d);
`else
    return (d == 8'h00) & p & 1'b0;
`endif
  endfunction

  task automatic drive_bit(input logic b);
    serialIn = b;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  // Sends one frame then idles; the model decides delivery/drop from rx_ready and whether a character is held.
  task automatic frame(input logic [7:0] d, input logic stop, input logic p);
    logic mm;
    mm = mism(d, p);
    drive_bit(1'b0);
    for (int i = 0; i < DB; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit(p);
`endif
    drive_bit(stop);
    if (rx_ready) begin
      exp_q.push_back({~stop, mm, d});
    end else if (!held) begin
      held    = 1'b1;
      held_ch = {~stop, mm, d};
    end else begin
      m_err[2] = 1'b1;
    end
    m_err[0] = m_err[0] | ~stop;
    m_err[1] = m_err[1] | mm;
    serialIn = 1'b1;
    repeat (2 * CPB) @(posedge clk);
    #1;
  endtask

  task automatic status(input string tag);
    @(negedge clk);
    check({tag, "_err"}, 32'(err), 32'(m_err));
    check({tag, "_vld"}, 32'(rx_valid), 32'(held));
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string tag);
    check({tag, "_n"}, 32'(got_q.size()), 32'(exp_q.size()));
    while (got_q.size() > 0 && exp_q.size() > 0)
      check({tag, "_ch"}, 32'(got_q.pop_front()), 32'(exp_q.pop_front()));
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic clear_err();
    err_clear = 1'b1;
    @(posedge clk);
    #1;
    err_clear = 1'b0;
    m_err = 3'b000;
  endtask

  task automatic reset_checks(input string tag);
    @(negedge clk);
    check({tag, "_data"}, 32'(rx_data), 32'd0);
    check({tag, "_vld"}, 32'(rx_valid), 32'd0);
    check({tag, "_fe"}, 32'(frame_err), 32'd0);
    check({tag, "_pe"}, 32'(parity_err), 32'd0);
    check({tag, "_err"}, 32'(err), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] d;
    logic       stop, p;
    repeat (3) @(posedge clk);
    #1;
    reset_checks("rst");
    reset = 1'b0;
    repeat (4) @(posedge clk);
    #1;

    frame(8'hA5, 1'b1, good_par(8'hA5));
    drain("a5");
    status("a5");

    serialIn = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    serialIn = 1'b1;
    repeat (3 * CPB) @(posedge clk);
    #1;
    drain("glitch");
    status("glitch");

    frame(8'h3C, 1'b0, good_par(8'h3C));
    drain("frm");
    status("frm");
    clear_err();
    status("frm_clr");

    rx_ready = 1'b0;
    frame(8'h11, 1'b1, good_par(8'h11));
    frame(8'h22, 1'b1, good_par(8'h22));
    @(negedge clk);
    check("ovr_data", 32'(rx_data), 32'h11);
    @(posedge clk);
    #1;
    status("ovr");
    rx_ready = 1'b1;
    exp_q.push_back(held_ch);
    held = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("ovr_drop", 32'(rx_valid), 32'd0);
    @(posedge clk);
    #1;
    drain("ovr");
    clear_err();
    status("ovr_clr");

`ifdef UART_RX_PARITY_EN
    frame(8'h07, 1'b1, 1'b0);
    drain("par_bad");
    status("par_bad");
    clear_err();
    frame(8'h07, 1'b1, 1'b1);
    drain("par_ok");
    status("par_ok");
`endif

    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    drive_bit(1'b1);
    reset = 1'b1;
    serialIn = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset_checks("midrst");
    reset = 1'b0;
    m_err = 3'b000;
    held = 1'b0;
    got_q.delete();
    exp_q.delete();
    repeat (2 * CPB) @(posedge clk);
    #1;
    frame(8'h5A, 1'b1, good_par(8'h5A));
    drain("5a");
    status("5a");

    for (int n = 0; n < 24; n++) begin
      d    = 8'($urandom_range(0, 255));
      stop = ($urandom_range(0, 5) != 0);
      p    = good_par(d) ^ ($urandom_range(0, 3) == 0);
      frame(d, stop, p);
      drain("rnd");
      status("rnd");
      if ($urandom_range(0, 2) == 0) clear_err();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
